// File: rtl/register_window_control.sv
// SPARC window control: owns CWP and WIM, performs SAVE/RESTORE/RETT moves and raises held overflow/underflow traps.
// Optional per-type trap entry counters are built only when WINDOW_TRAP_COUNT_EN is defined.
module register_window_control #(
   parameter int                    NWINDOWS  = 8,
   parameter logic [NWINDOWS-1:0]   WIM_RESET = '0
) (
   input  logic                 Clock,
   input  logic                 Reset_N,
   input  logic                 Save,
   input  logic                 Restore,
   input  logic                 Rett,
   input  logic                 Wr_CWP,
   input  logic [4:0]           CWP_In,
   input  logic                 Wr_WIM,
   input  logic [NWINDOWS-1:0]  WIM_In,
   input  logic                 Trap_Ack,
   output logic [4:0]           Current_Window_Pointer,
   output logic [NWINDOWS-1:0]  WIM,
   output logic                 Window_Overflow,
   output logic                 Window_Underflow,
   output logic                 Stall,
   output logic                 Op_Error,
   output logic [15:0]          Overflow_Count,
   output logic [15:0]          Underflow_Count
);

   localparam int         IDXW    = (NWINDOWS > 1) ? $clog2(NWINDOWS) : 1;
   localparam logic [4:0] CWP_MAX = 5'(NWINDOWS - 1);
   localparam logic [5:0] NW      = 6'(NWINDOWS);

   typedef enum logic {IDLE, TRAP} state_t;

   state_t               state_q, state_d;
   logic [4:0]           cwp_q, cwp_d;
   logic [NWINDOWS-1:0]  wim_q, wim_d;
   logic                 ovf_q, ovf_d;
   logic                 unf_q, unf_d;
   logic                 err_q, err_d;
   logic                 ovf_evt, unf_evt;

   logic [4:0]           cwp_down, cwp_up;
   logic                 wim_down, wim_up;
   logic                 move_up;
   logic                 cwp_in_ok;

   assign cwp_down  = (cwp_q == 5'd0)    ? CWP_MAX : cwp_q - 5'd1;
   assign cwp_up    = (cwp_q == CWP_MAX) ? 5'd0    : cwp_q + 5'd1;
   assign wim_down  = wim_q[cwp_down[IDXW-1:0]];
   assign wim_up    = wim_q[cwp_up[IDXW-1:0]];
   assign move_up   = Restore | Rett;
   assign cwp_in_ok = ({1'b0, CWP_In} < NW);

   // State register
   always_ff @(posedge Clock or negedge Reset_N) begin
      if (!Reset_N) begin
         state_q <= IDLE;
         cwp_q   <= 5'd0;
         wim_q   <= WIM_RESET;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q <= state_d;
         cwp_q   <= cwp_d;
         wim_q   <= wim_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
         err_q   <= err_d;
      end
   end

   // Next-state logic; the window check always uses the WIM held before this edge
   always_comb begin
      // NOTE: defaults first so no path leaves a signal unassigned (no latches).
      state_d = state_q;
      cwp_d   = cwp_q;
      wim_d   = Wr_WIM ? WIM_In : wim_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      err_d   = 1'b0;
      ovf_evt = 1'b0;
      unf_evt = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (Wr_CWP) begin
               if (cwp_in_ok) cwp_d = CWP_In;
               else           err_d = 1'b1;
            end else if (Save && move_up) begin
               err_d = 1'b1;
            end else if (Save) begin
               if (wim_down) begin
                  ovf_d   = 1'b1;
                  ovf_evt = 1'b1;
                  state_d = TRAP;
               end else begin
                  cwp_d = cwp_down;
               end
            end else if (move_up) begin
               if (wim_up) begin
                  unf_d   = 1'b1;
                  unf_evt = 1'b1;
                  state_d = TRAP;
               end else begin
                  cwp_d = cwp_up;
               end
            end
         end
         TRAP: begin
            // Trap entry decrements the window without consulting WIM
            if (Trap_Ack) begin
               ovf_d   = 1'b0;
               unf_d   = 1'b0;
               cwp_d   = cwp_down;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      Current_Window_Pointer = cwp_q;
      WIM                    = wim_q;
      Window_Overflow        = ovf_q;
      Window_Underflow       = unf_q;
      Stall                  = (state_q == TRAP);
      Op_Error               = err_q;
   end

`ifdef WINDOW_TRAP_COUNT_EN
   logic [15:0] ovf_cnt_q, unf_cnt_q;

   always_ff @(posedge Clock or negedge Reset_N) begin
      if (!Reset_N) begin
         ovf_cnt_q <= 16'd0;
         unf_cnt_q <= 16'd0;
      end else begin
         if (ovf_evt && (ovf_cnt_q != 16'hFFFF)) ovf_cnt_q <= ovf_cnt_q + 16'd1;
         if (unf_evt && (unf_cnt_q != 16'hFFFF)) unf_cnt_q <= unf_cnt_q + 16'd1;
      end
   end

   assign Overflow_Count  = ovf_cnt_q;
   assign Underflow_Count = unf_cnt_q;
`else
   logic unused_evt;
   assign unused_evt      = ovf_evt ^ unf_evt;
   assign Overflow_Count  = 16'd0;
   assign Underflow_Count = 16'd0;
`endif

endmodule

// File: tb/tb_register_window_control.sv
// Bench for register_window_control: directed vector table, reset-during-trap sequence,
// then random traffic against a window-arithmetic reference model.
module tb_register_window_control;

   localparam int N = 8;
`ifdef WINDOW_TRAP_COUNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic          Clock = 1'b0;
   logic          Reset_N;
   logic          Save, Restore, Rett, Wr_CWP, Wr_WIM, Trap_Ack;
   logic [4:0]    CWP_In;
   logic [N-1:0]  WIM_In;
   logic [4:0]    Current_Window_Pointer;
   logic [N-1:0]  WIM;
   logic          Window_Overflow, Window_Underflow, Stall, Op_Error;
   logic [15:0]   Overflow_Count, Underflow_Count;

   register_window_control #(.NWINDOWS(N), .WIM_RESET(8'h00)) dut (
      .Clock                  (Clock),
      .Reset_N                (Reset_N),
      .Save                   (Save),
      .Restore                (Restore),
      .Rett                   (Rett),
      .Wr_CWP                 (Wr_CWP),
      .CWP_In                 (CWP_In),
      .Wr_WIM                 (Wr_WIM),
      .WIM_In                 (WIM_In),
      .Trap_Ack               (Trap_Ack),
      .Current_Window_Pointer (Current_Window_Pointer),
      .WIM                    (WIM),
      .Window_Overflow        (Window_Overflow),
      .Window_Underflow       (Window_Underflow),
      .Stall                  (Stall),
      .Op_Error               (Op_Error),
      .Overflow_Count         (Overflow_Count),
      .Underflow_Count        (Underflow_Count)
   );

   always #5 Clock = ~Clock;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   typedef struct {
      int save, restore, rett, wr_cwp, cwp_in, wr_wim, wim_in, ack;
      int e_cwp, e_wim, e_ovf, e_unf, e_stall, e_err, e_oc, e_uc;
   } vec_t;

   vec_t vq[$];

   task automatic clear_inputs();
      Save = 1'b0; Restore = 1'b0; Rett = 1'b0; Wr_CWP = 1'b0; CWP_In = 5'd0;
      Wr_WIM = 1'b0; WIM_In = '0; Trap_Ack = 1'b0;
   endtask

   task automatic check_outputs(input string tag, input int cwp, input int wim, input int ovf,
                                input int unf, input int stall, input int err, input int oc, input int uc);
      check({tag, " cwp"},   32'(Current_Window_Pointer), cwp);
      check({tag, " wim"},   32'(WIM), wim);
      check({tag, " ovf"},   32'(Window_Overflow), ovf);
      check({tag, " unf"},   32'(Window_Underflow), unf);
      check({tag, " stall"}, 32'(Stall), stall);
      check({tag, " err"},   32'(Op_Error), err);
      check({tag, " ovf_cnt"}, 32'(Overflow_Count), CNT_EN ? oc : 0);
      check({tag, " unf_cnt"}, 32'(Underflow_Count), CNT_EN ? uc : 0);
   endtask

   task automatic apply_vec(input int idx);
      vec_t v;
      v = vq[idx];
      Save     = v.save[0];
      Restore  = v.restore[0];
      Rett     = v.rett[0];
      Wr_CWP   = v.wr_cwp[0];
      CWP_In   = v.cwp_in[4:0];
      Wr_WIM   = v.wr_wim[0];
      WIM_In   = v.wim_in[N-1:0];
      Trap_Ack = v.ack[0];
      @(posedge Clock);
      #1;
      clear_inputs();
      check_outputs($sformatf("vec%0d", idx), v.e_cwp, v.e_wim, v.e_ovf, v.e_unf,
                    v.e_stall, v.e_err, v.e_oc, v.e_uc);
   endtask

   // Reference model state
   int        m_cwp, m_oc, m_uc;
   bit [N-1:0] m_wim;
   bit        m_ovf, m_unf, m_err;

   initial begin
      int split;
      //          sv rs rt wc ci ww wi ak | cwp wim ovf unf stl err oc uc
      vq.push_back('{0,0,0,0,0, 0,0,    0,  0, 'h00,0,0,0,0, 0,0});
      vq.push_back('{1,0,0,0,0, 0,0,    0,  7, 'h00,0,0,0,0, 0,0});
      vq.push_back('{1,0,0,0,0, 0,0,    0,  6, 'h00,0,0,0,0, 0,0});
      vq.push_back('{1,0,0,0,0, 0,0,    0,  5, 'h00,0,0,0,0, 0,0});
      vq.push_back('{0,0,0,1,7, 0,0,    0,  7, 'h00,0,0,0,0, 0,0});
      vq.push_back('{0,1,0,0,0, 0,0,    0,  0, 'h00,0,0,0,0, 0,0});
      vq.push_back('{0,0,1,0,0, 0,0,    0,  1, 'h00,0,0,0,0, 0,0});
      vq.push_back('{0,0,0,1,3, 1,'h04, 0,  3, 'h04,0,0,0,0, 0,0});
      vq.push_back('{1,0,0,0,0, 0,0,    0,  3, 'h04,1,0,1,0, 1,0});
      vq.push_back('{1,0,0,0,0, 0,0,    0,  3, 'h04,1,0,1,0, 1,0});
      vq.push_back('{0,0,0,0,0, 0,0,    1,  2, 'h04,0,0,0,0, 1,0});
      vq.push_back('{0,0,0,0,0, 1,'h10, 0,  2, 'h10,0,0,0,0, 1,0});
      vq.push_back('{0,0,0,1,3, 0,0,    0,  3, 'h10,0,0,0,0, 1,0});
      vq.push_back('{0,1,0,0,0, 0,0,    0,  3, 'h10,0,1,1,0, 1,1});
      vq.push_back('{1,0,0,1,6, 0,0,    0,  3, 'h10,0,1,1,0, 1,1});
      split = vq.size();
      vq.push_back('{0,0,0,1,9, 0,0,    0,  0, 'h00,0,0,0,1, 0,0});
      vq.push_back('{0,0,0,0,0, 0,0,    0,  0, 'h00,0,0,0,0, 0,0});
      vq.push_back('{1,1,0,0,0, 0,0,    0,  0, 'h00,0,0,0,1, 0,0});
      vq.push_back('{1,0,0,1,5, 0,0,    0,  5, 'h00,0,0,0,0, 0,0});
      vq.push_back('{0,0,0,1,2, 0,0,    0,  2, 'h00,0,0,0,0, 0,0});
      vq.push_back('{1,0,0,0,0, 1,'h02, 0,  1, 'h02,0,0,0,0, 0,0});
      vq.push_back('{1,0,0,0,0, 0,0,    0,  0, 'h02,0,0,0,0, 0,0});
      vq.push_back('{0,0,0,1,2, 0,0,    0,  2, 'h02,0,0,0,0, 0,0});
      vq.push_back('{1,0,0,0,0, 0,0,    0,  2, 'h02,1,0,1,0, 1,0});
      vq.push_back('{0,0,0,0,0, 1,'h06, 0,  2, 'h06,1,0,1,0, 1,0});
      vq.push_back('{0,0,0,0,0, 1,'h00, 1,  1, 'h00,0,0,0,0, 1,0});
      vq.push_back('{0,0,0,0,0, 0,0,    1,  1, 'h00,0,0,0,0, 1,0});
      vq.push_back('{0,0,0,1,31,0,0,    0,  1, 'h00,0,0,0,1, 1,0});
      vq.push_back('{1,0,1,0,0, 0,0,    0,  1, 'h00,0,0,0,1, 1,0});

      clear_inputs();
      Reset_N = 1'b0;
      repeat (2) @(posedge Clock);
      #1;
      check_outputs("reset", 0, 0, 0, 0, 0, 0, 0, 0);
      Reset_N = 1'b1;

      for (int i = 0; i < split; i++) apply_vec(i);

      // Reset asserted while the underflow trap is still pending takes effect at once
      #2 Reset_N = 1'b0;
      #1;
      check_outputs("rst_mid_trap", 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge Clock);
      Reset_N = 1'b1;
      @(posedge Clock);
      #1;

      for (int i = split; i < vq.size(); i++) apply_vec(i);

      // Random traffic against the reference model
      Reset_N = 1'b0;
      #2;
      Reset_N = 1'b1;
      m_cwp = 0; m_wim = '0; m_ovf = 0; m_unf = 0; m_err = 0; m_oc = 0; m_uc = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         int d, u;
         Save     = ($urandom_range(0, 2) == 0);
         Restore  = ($urandom_range(0, 3) == 0);
         Rett     = ($urandom_range(0, 5) == 0);
         Wr_CWP   = ($urandom_range(0, 9) == 0);
         CWP_In   = 5'($urandom_range(0, 11));
         Wr_WIM   = ($urandom_range(0, 7) == 0);
         WIM_In   = N'($urandom & $urandom);
         Trap_Ack = ($urandom_range(0, 2) == 0);

         d = (m_cwp + N - 1) % N;
         u = (m_cwp + 1) % N;
         m_err = 0;
         if (m_ovf || m_unf) begin
            if (Trap_Ack) begin
               m_ovf = 0; m_unf = 0; m_cwp = d;
            end
         end else if (Wr_CWP) begin
            if (int'(CWP_In) < N) m_cwp = int'(CWP_In);
            else                  m_err = 1;
         end else if (Save && (Restore || Rett)) begin
            m_err = 1;
         end else if (Save) begin
            if (m_wim[d]) begin m_ovf = 1; m_oc++; end
            else m_cwp = d;
         end else if (Restore || Rett) begin
            if (m_wim[u]) begin m_unf = 1; m_uc++; end
            else m_cwp = u;
         end
         if (Wr_WIM) m_wim = WIM_In;

         @(posedge Clock);
         #1;
         clear_inputs();
         check_outputs("rand", m_cwp, int'(m_wim), int'(m_ovf), int'(m_unf),
                       int'(m_ovf || m_unf), int'(m_err), m_oc, m_uc);
         check("rand excl", 32'(Window_Overflow & Window_Underflow), 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
